// File: rtl/pwm_duty_decoder_if.sv
// PWM line plus decoded-result bundle between a PWM source/observer and the
// duty decoder. The master drives the PWM line and watches the results; the
// slave (the decoder) samples the line and publishes the results.
interface pwm_duty_decoder_if;
  logic       pwm_in;
  logic [3:0] code;
  logic       code_valid;
  logic       period_err;
  logic       idle;
  logic       locked;

  modport master (
    output pwm_in,
    input  code,
    input  code_valid,
    input  period_err,
    input  idle,
    input  locked
  );

  modport slave (
    input  pwm_in,
    output code,
    output code_valid,
    output period_err,
    output idle,
    output locked
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: recovers the 4-bit duty code from an asynchronous PWM
// line by measuring high time and rise-to-rise period, quantising the high
// time into STEP-sized units with round-half-up, and flagging period errors,
// static (idle) lines and a stable (locked) code.
module pwm_duty_decoder #(
  parameter int PERIOD = 27000,
  parameter int STEP   = PERIOD / 16,
  parameter int TOL    = 256,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst_n,
  pwm_duty_decoder_if.slave pwm
);

  localparam int LEN_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP - 1);
  localparam logic [CNT_W-1:0] STEP_HALF = CNT_W'(STEP / 2);
  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(PERIOD + TOL);
  localparam logic [LEN_W-1:0] NOM_LEN   = LEN_W'(PERIOD + 1);
  localparam logic [LEN_W-1:0] TOL_LEN   = LEN_W'(TOL);

  typedef enum logic [1:0] {
    WAIT_EDGE,
    MEASURE,
    EMIT
  } state_t;

  state_t state;
  state_t state_next;

  logic s1;
  logic s2;
  logic s2_d;
  logic rise;
  logic timeout;
  logic frame_end;
  logic idle_end;

  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] step_cnt;
  logic [3:0]       quanta;

  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] len_diff;
  logic [4:0]       rounded;
  logic [3:0]       frame_code;
  logic             frame_err;

  logic [3:0] pend_code;
  logic       pend_err;
  logic       pend_idle;
  logic       prev_ok;

  logic [3:0] code_q;
  logic       valid_q;
  logic       err_q;
  logic       idle_q;
  logic       locked_q;

  assign rise    = s2 & ~s2_d;
  assign timeout = (period_cnt == TIMEOUT);

  // Two-flop synchroniser for the asynchronous line, plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= pwm.pwm_in;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_EDGE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a rise beats a simultaneous timeout so that frame stays normal
  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    idle_end   = 1'b0;
    case (state)
      WAIT_EDGE: begin
        if (rise) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          state_next = EMIT;
          frame_end  = 1'b1;
        end else if (timeout) begin
          state_next = EMIT;
          frame_end  = 1'b1;
          idle_end   = 1'b1;
        end
      end
      EMIT: begin
        state_next = MEASURE;
      end
      default: begin
        state_next = WAIT_EDGE;
      end
    endcase
  end

  // Frame result from the running counters: rounded, saturated code and period check
  always_comb begin
    frame_len = {1'b0, period_cnt} + LEN_W'(1);
    if (frame_len > NOM_LEN) begin
      len_diff = frame_len - NOM_LEN;
    end else begin
      len_diff = NOM_LEN - frame_len;
    end
    frame_err  = (len_diff > TOL_LEN);
    rounded    = {1'b0, quanta} + ((step_cnt >= STEP_HALF) ? 5'd1 : 5'd0);
    frame_code = rounded[4] ? 4'd15 : rounded[3:0];
  end

  // Period and high-time counters; the frame-starting rise cycle restarts them at zero
  // and the EMIT cycle already counts towards the new frame, so no cycle is lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt <= '0;
      step_cnt   <= '0;
      quanta     <= '0;
    end else if ((state == WAIT_EDGE && rise) || frame_end) begin
      period_cnt <= '0;
      step_cnt   <= '0;
      quanta     <= '0;
    end else if (state != WAIT_EDGE) begin
      period_cnt <= period_cnt + CNT_W'(1);
      if (s2) begin
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          if (quanta != 4'd15) begin
            quanta <= quanta + 4'd1;
          end
        end else begin
          step_cnt <= step_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Capture the finished frame's result for publication in the EMIT cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_code <= '0;
      pend_err  <= 1'b0;
      pend_idle <= 1'b0;
    end else if (frame_end) begin
      if (idle_end) begin
        pend_code <= s2 ? 4'd15 : 4'd0;
        pend_err  <= 1'b0;
        pend_idle <= 1'b1;
      end else begin
        pend_code <= frame_code;
        pend_err  <= frame_err;
        pend_idle <= 1'b0;
      end
    end
  end

  // Publish results and the valid pulse; lock needs two good frames with the same code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      idle_q   <= 1'b0;
      locked_q <= 1'b0;
      prev_ok  <= 1'b0;
    end else begin
      valid_q <= (state == EMIT);
      if (state == EMIT) begin
        code_q   <= pend_code;
        err_q    <= pend_err;
        idle_q   <= pend_idle;
        locked_q <= !pend_idle && !pend_err && prev_ok && (pend_code == code_q);
        prev_ok  <= !pend_idle && !pend_err;
      end
    end
  end

  assign pwm.code       = code_q;
  assign pwm.code_valid = valid_q;
  assign pwm.period_err = err_q;
  assign pwm.idle       = idle_q;
  assign pwm.locked     = locked_q;

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the 4-bit switch-driven PWM generator. Recovers the 4-bit duty code from a PWM waveform.
- Samples an asynchronous PWM line. Measures high time and period between rising edges, then quantizes high time into 16 steps.
- Publishes the code with a valid pulse, plus status flags. Used for loopback self-test of the LED PWM path and for reading PWM from external sources.

Parameters:
- PERIOD, 27000: nominal frame length in clk cycles (1 ms at 27 MHz); the generator frame is PERIOD+1 cycles.
- STEP, PERIOD/16 = 1687: clk cycles per duty code unit.
- TOL, 256: allowed period deviation in cycles before period_err is flagged.
- CNT_W, 16: width of internal counters; must hold PERIOD+TOL.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- pwm_in  input  1  asynchronous PWM line
- code  output  4  last decoded duty code
- code_valid  output  1  one-cycle pulse when code is updated
- period_err  output  1  last frame's period was outside PERIOD+1 ± TOL
- idle  output  1  no rising edge seen for PERIOD+1+TOL cycles (static line)
- locked  output  1  two consecutive valid frames decoded the same code with period_err=0

Behaviour:
- Reset: one clk with rst_n=0 clears all state. Outputs then read code=0, code_valid=0, period_err=0, idle=0, locked=0.
- Reset takes priority over every other event. Reset mid-frame discards the partial frame; the next rising edge only starts a frame and emits nothing.
- Input path: 2-flop synchronizer, then one registered copy for edge detection. rise = s2 & ~s2_d.
- Fixed latency: the rising edge of pwm_in first sampled high at clk edge N gives code_valid=1 in the cycle after edge N+3.
- States are WAIT_EDGE, MEASURE and EMIT.
  - WAIT_EDGE (after reset): on rise, clear counters and go to MEASURE. No output.
  - MEASURE: period_cnt increments every cycle. While s2=1, the step counter increments and wraps at STEP-1; each wrap increments quanta, which saturates at 15. Rem holds the step counter value.
  - MEASURE on rise: go to EMIT with frame length = period_cnt+1.
  - MEASURE on timeout (period_cnt reaches PERIOD+TOL without a rise): go to EMIT as an idle frame.
  - EMIT (one cycle): code = quanta + (rem >= STEP/2), saturated to 15. Pulse code_valid. Clear counters and return to MEASURE. The rise that ended the frame is the first edge of the new frame, so no cycles are lost.
- Idle frame rules:
  - code = 0 if s2=0 and 15 if s2=1. Set idle=1 and period_err=0. A valid pulse is emitted every PERIOD+TOL+1 cycles while the line stays static.
  - idle clears on the next normal EMIT.
- period_err is set on EMIT when |frame_len − (PERIOD+1)| > TOL, and cleared otherwise. A frame with period_err still updates code.
- locked:
  - Set on EMIT when the new code equals the previous code, and both frames are normal with period_err=0.
  - Cleared on any EMIT that breaks that condition, and on reset.
- code, period_err, idle and locked change only in the EMIT cycle and hold between pulses.
- Rise and timeout in the same cycle: rise wins, and the frame is normal.
- Arithmetic is all unsigned; there are no dividers or multipliers.

Test Plan:
- Generator pattern for code 5 (high 8435, frame 27001), three frames -> code_valid pulses exactly 27001 cycles apart; code=5, period_err=0, idle=0; locked=1 from the 2nd pulse onward.
- High 1687×3+844 = 5905 vs. 5904 cycles, frame 27001 -> codes 4 and 3 respectively (rounding threshold).
- pwm_in held 0 for 60000 cycles after one frame of code 7 -> code=7 first, then idle pulses with code=0, idle=1, spaced 27257 cycles; locked=0. Repeat with pwm_in held 1 -> code=15, idle=1.
- Frames of 20000 cycles with high 3374 -> code=2, period_err=1, locked=0. Return to 27001 -> period_err=0 on the first good frame and locked=1 on the second.
- Assert rst_n=0 for 1 cycle mid-MEASURE of a code-9 stream -> all outputs 0. No code_valid at the next rise; the first pulse comes one full frame later with code=9.
- Code sweep 0..15 from the generator model, 2 frames each -> every decoded code equals the driven code (codes 1..15 normal; code 0 via idle).
